// File: rtl/pool_ctrl.sv
// pool_ctrl: 2x2 / stride-2 signed max pooling over the conv output feature map.
// Reads four psums per window from OFMAP_BASE, writes one max per window to POOL_BASE.
// Optional build macro POOL_RELU_EN: clamp negative pooled results to zero on write.
//
// Ports
//   clk, srst      clock (rising edge), synchronous active-high reset
//   enable         start pulse, only honoured in IDLE
//   num_chnl       channel count (1..16), latched at start
//   ofmap_height   ofmap rows (0..28), latched at start
//   ofmap_width    ofmap cols (0..28), latched at start
//   data_in        DRAM read data, valid one cycle after addr_in
//   addr_in        DRAM read address
//   dram_en_rd     DRAM read enable
//   addr_out       DRAM write address
//   data_out       DRAM write data (combinational from data_in during WR)
//   dram_en_wr     DRAM write enable
//   done           one-cycle completion pulse
module pool_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter logic [ADDR_WIDTH-1:0] OFMAP_BASE = ADDR_WIDTH'(131072),
  parameter logic [ADDR_WIDTH-1:0] POOL_BASE  = ADDR_WIDTH'(196608)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic [4:0]            num_chnl,
  input  logic [5:0]            ofmap_height,
  input  logic [5:0]            ofmap_width,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  dram_en_rd,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  dram_en_wr,
  output logic                  done
);

  typedef enum logic [6:0] {
    IDLE = 7'b0000001,
    RD0  = 7'b0000010,
    RD1  = 7'b0000100,
    RD2  = 7'b0001000,
    RD3  = 7'b0010000,
    WR   = 7'b0100000,
    DONE = 7'b1000000
  } state_t;

  state_t                  state_q, nxt;
  logic [3:0]              c_q, c_n;
  logic [3:0]              py_q, py_n;
  logic [3:0]              px_q, px_n;
  logic [4:0]              nch_q, ph_q, pw_q;
  logic [DATA_WIDTH-1:0]   run_max_q;
  logic [DATA_WIDTH-1:0]   max_c;
  logic                    latch_dims;
  logic                    rd_en_n, wr_en_n, done_n;
  logic [ADDR_WIDTH-1:0]   rd_addr_n, wr_addr_n;
  logic                    px_last, py_last, c_last;
  logic                    row_bit, col_bit;

  function automatic logic [DATA_WIDTH-1:0] smax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // Next state, next counters and next values of the registered DRAM controls.
  always_comb begin
    nxt        = state_q;
    c_n        = c_q;
    py_n       = py_q;
    px_n       = px_q;
    latch_dims = 1'b0;
    px_last    = (5'(px_q) == pw_q - 5'd1);
    py_last    = (5'(py_q) == ph_q - 5'd1);
    c_last     = (5'(c_q) == nch_q - 5'd1);

    case (state_q)
      IDLE: begin
        c_n  = 4'd0;
        py_n = 4'd0;
        px_n = 4'd0;
        if (enable) begin
          latch_dims = 1'b1;
          // Fewer than 2 rows/cols means no complete window.
          if (num_chnl == 5'd0 || ofmap_width < 6'd2 || ofmap_height < 6'd2) nxt = DONE;
          else                                                              nxt = RD0;
        end
      end
      RD0: nxt = RD1;
      RD1: nxt = RD2;
      RD2: nxt = RD3;
      RD3: nxt = WR;
      WR: begin
        if (px_last) begin
          px_n = 4'd0;
          if (py_last) begin
            py_n = 4'd0;
            c_n  = c_q + 4'd1;
          end else begin
            py_n = py_q + 4'd1;
          end
        end else begin
          px_n = px_q + 4'd1;
        end
        nxt = (px_last && py_last && c_last) ? DONE : RD0;
      end
      DONE: begin
        c_n  = 4'd0;
        py_n = 4'd0;
        px_n = 4'd0;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase

    // Registered outputs are computed from the next state so they line up with it.
    row_bit   = (nxt == RD2) || (nxt == RD3);
    col_bit   = (nxt == RD1) || (nxt == RD3);
    rd_en_n   = (nxt == RD0) || (nxt == RD1) || (nxt == RD2) || (nxt == RD3);
    wr_en_n   = (nxt == WR);
    done_n    = (nxt == DONE);
    rd_addr_n = '0;
    wr_addr_n = '0;
    if (rd_en_n) rd_addr_n = OFMAP_BASE + ADDR_WIDTH'({c_n, py_n, row_bit, px_n, col_bit});
    if (wr_en_n) wr_addr_n = POOL_BASE + ADDR_WIDTH'({c_n, 1'b0, py_n, 1'b0, px_n});
  end

  // State, counters, latched dimensions, running max and DRAM control registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= IDLE;
      c_q        <= '0;
      py_q       <= '0;
      px_q       <= '0;
      nch_q      <= '0;
      ph_q       <= '0;
      pw_q       <= '0;
      run_max_q  <= '0;
      addr_in    <= '0;
      dram_en_rd <= 1'b0;
      addr_out   <= '0;
      dram_en_wr <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= nxt;
      c_q        <= c_n;
      py_q       <= py_n;
      px_q       <= px_n;
      addr_in    <= rd_addr_n;
      dram_en_rd <= rd_en_n;
      addr_out   <= wr_addr_n;
      dram_en_wr <= wr_en_n;
      done       <= done_n;
      if (latch_dims) begin
        nch_q <= num_chnl;
        ph_q  <= ofmap_height[5:1];
        pw_q  <= ofmap_width[5:1];
      end
      // data_in in RD1 carries the RD0 word, in RD2/RD3 the RD1/RD2 words.
      if (state_q == RD1)                        run_max_q <= data_in;
      else if (state_q == RD2 || state_q == RD3) run_max_q <= smax(run_max_q, data_in);
    end
  end

  // Write data folds in the RD3 word, which only arrives during WR.
  always_comb begin
    max_c    = smax(run_max_q, data_in);
    data_out = '0;
    if (state_q == WR) begin
`ifdef POOL_RELU_EN
      data_out = max_c[DATA_WIDTH-1] ? '0 : max_c;
`else
      data_out = max_c;
`endif
    end
  end

endmodule
